// File: rtl/fft_mag_peak.sv
// ---------------------------------------------------------------------------
// fft_mag_peak
//
// Streaming magnitude and peak-bin stage placed directly after dft_top. Each
// data cycle carries two complex bins (even bin 2c on Y0/Y1, odd bin 2c+1 on
// Y2/Y3). Every bin gets an alpha-max-beta-min magnitude, and once per frame
// the strongest bin inside [SRCH_LO, SRCH_HI] is reported.
//
// Optional feature macro: FFT_MAG_PEAK_EN
//   defined     -> peak tracker (S4) and peak_* outputs are built
//   not defined -> peak_valid / peak_bin / peak_mag are tied to 0
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   next_out    one-cycle frame-start pulse, first data on the following cycle
//   Y0, Y1      real / imaginary part of even bin (two's complement)
//   Y2, Y3      real / imaginary part of odd bin (two's complement)
//   mag_valid   mag0 / mag1 / mag_bin valid this cycle
//   mag0, mag1  magnitude of even / odd bin (unsigned)
//   mag_bin     index of the even bin
//   peak_valid  one-cycle pulse when a completed frame's peak is published
//   peak_bin    index of the strongest in-window bin (held until next pulse)
//   peak_mag    magnitude at peak_bin (held until next pulse)
// ---------------------------------------------------------------------------
module fft_mag_peak #(
   parameter int DW        = 12,
   parameter int FRAME_CYC = 1024,
   parameter int BIN_W     = 11,
   parameter int SRCH_LO   = 2,
   parameter int SRCH_HI   = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             next_out,
   input  logic [DW-1:0]    Y0,
   input  logic [DW-1:0]    Y1,
   input  logic [DW-1:0]    Y2,
   input  logic [DW-1:0]    Y3,
   output logic             mag_valid,
   output logic [DW-1:0]    mag0,
   output logic [DW-1:0]    mag1,
   output logic [BIN_W-1:0] mag_bin,
   output logic             peak_valid,
   output logic [BIN_W-1:0] peak_bin,
   output logic [DW-1:0]    peak_mag
);

   // Elaboration-time sanity check of the search window and index width
   if (SRCH_LO > SRCH_HI || SRCH_HI >= 2 * FRAME_CYC || (2 * FRAME_CYC) > (1 << BIN_W)) begin : g_param_check
      $error("fft_mag_peak: search window or BIN_W inconsistent with FRAME_CYC");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [BIN_W-1:0] LAST_CNT = BIN_W'(FRAME_CYC - 1);

   state_t           state;
   logic [BIN_W-1:0] cnt;
   logic             capture;

   logic             s1_valid;
   logic             s1_last;
   logic [BIN_W-1:0] s1_bin;
   logic [DW-1:0]    abs_re0;
   logic [DW-1:0]    abs_im0;
   logic [DW-1:0]    abs_re1;
   logic [DW-1:0]    abs_im1;

   logic             s2_valid;
   logic             s2_last;
   logic [BIN_W-1:0] s2_bin;
   logic [DW-1:0]    max0;
   logic [DW-1:0]    min0;
   logic [DW-1:0]    max1;
   logic [DW-1:0]    min1;

   logic             s3_last;

   // Two's-complement negate in DW bits. The most negative input maps to
   // 2^(DW-1), which is still representable as an unsigned DW-bit value.
   function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
      if (x[DW-1])
         return (~x) + DW'(1);
      else
         return x;
   endfunction

   // max + min/4 + min/8; bounded by 1.375 * 2^(DW-1), so no carry out of DW
   function automatic logic [DW-1:0] amb_mag(input logic [DW-1:0] mx, input logic [DW-1:0] mn);
      return mx + (mn >> 2) + (mn >> 3);
   endfunction

   // A data set is taken every RUN cycle except the one carrying next_out,
   // which restarts the frame instead.
   assign capture = (state == RUN) && !next_out;

   // Frame control. next_out in RUN aborts the frame: its last data set is
   // never captured, so it can never raise a last flag or a peak pulse.
   // next_out in FLUSH starts the next frame immediately; the previous frame
   // is already completely inside the pipe and finishes on its own.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (next_out) begin
                  state <= RUN;
                  cnt   <= '0;
               end
            end
            RUN: begin
               if (next_out) begin
                  cnt <= '0;
               end else if (cnt == LAST_CNT) begin
                  state <= FLUSH;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + BIN_W'(1);
               end
            end
            FLUSH: begin
               if (next_out) begin
                  state <= RUN;
                  cnt   <= '0;
               end else if (s3_last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // S1: absolute values, the even-bin index and the end-of-frame marker
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_bin   <= '0;
         abs_re0  <= '0;
         abs_im0  <= '0;
         abs_re1  <= '0;
         abs_im1  <= '0;
      end else begin
         s1_valid <= capture;
         s1_last  <= capture && (cnt == LAST_CNT);
         if (capture) begin
            s1_bin  <= BIN_W'({cnt, 1'b0});
            abs_re0 <= abs_sat(Y0);
            abs_im0 <= abs_sat(Y1);
            abs_re1 <= abs_sat(Y2);
            abs_im1 <= abs_sat(Y3);
         end
      end
   end

   // S2: sort each bin's two components into max / min
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_bin   <= '0;
         max0     <= '0;
         min0     <= '0;
         max1     <= '0;
         min1     <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_last  <= s1_valid && s1_last;
         if (s1_valid) begin
            s2_bin <= s1_bin;
            max0   <= (abs_re0 >= abs_im0) ? abs_re0 : abs_im0;
            min0   <= (abs_re0 >= abs_im0) ? abs_im0 : abs_re0;
            max1   <= (abs_re1 >= abs_im1) ? abs_re1 : abs_im1;
            min1   <= (abs_re1 >= abs_im1) ? abs_im1 : abs_re1;
         end
      end
   end

   // S3: magnitude sums drive the outputs directly; values hold between frames
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mag_valid <= 1'b0;
         s3_last   <= 1'b0;
         mag_bin   <= '0;
         mag0      <= '0;
         mag1      <= '0;
      end else begin
         mag_valid <= s2_valid;
         s3_last   <= s2_valid && s2_last;
         if (s2_valid) begin
            mag_bin <= s2_bin;
            mag0    <= amb_mag(max0, min0);
            mag1    <= amb_mag(max1, min1);
         end
      end
   end

`ifdef FFT_MAG_PEAK_EN
   localparam logic [BIN_W-1:0] LO_BIN = BIN_W'(SRCH_LO);
   localparam logic [BIN_W-1:0] HI_BIN = BIN_W'(SRCH_HI);

   logic             s1_first;
   logic             s2_first;
   logic             s3_first;
   logic             in_even;
   logic             in_odd;
   logic [BIN_W-1:0] odd_bin;
   logic [BIN_W-1:0] base_bin;
   logic [BIN_W-1:0] pair_bin;
   logic [BIN_W-1:0] cand_bin;
   logic [BIN_W-1:0] run_bin;
   logic [DW-1:0]    base_mag;
   logic [DW-1:0]    pair_mag;
   logic [DW-1:0]    cand_mag;
   logic [DW-1:0]    run_mag;

   assign odd_bin = mag_bin | BIN_W'(1);

   // First-of-frame marker travels with the data, so the tracker is cleared
   // exactly when the new frame's first pair reaches S4. A previous frame
   // still draining in the pipe is therefore unaffected by a new next_out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_first <= 1'b0;
         s2_first <= 1'b0;
         s3_first <= 1'b0;
      end else begin
         s1_first <= capture && (cnt == '0);
         s2_first <= s1_valid && s1_first;
         s3_first <= s2_valid && s2_first;
      end
   end

   // Pair winner (odd only if strictly larger), then strict compare against
   // the running peak so equal magnitudes keep the lowest index.
   always_comb begin
      in_even  = (mag_bin >= LO_BIN) && (mag_bin <= HI_BIN);
      in_odd   = (odd_bin >= LO_BIN) && (odd_bin <= HI_BIN);
      base_bin = s3_first ? LO_BIN : run_bin;
      base_mag = s3_first ? '0 : run_mag;
      pair_bin = mag_bin;
      pair_mag = mag0;
      if (in_even && in_odd) begin
         if (mag1 > mag0) begin
            pair_bin = odd_bin;
            pair_mag = mag1;
         end
      end else if (in_odd) begin
         pair_bin = odd_bin;
         pair_mag = mag1;
      end
      cand_bin = base_bin;
      cand_mag = base_mag;
      if ((in_even || in_odd) && (pair_mag > base_mag)) begin
         cand_bin = pair_bin;
         cand_mag = pair_mag;
      end
   end

   // S4: running peak plus the published result, which holds between pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_bin    <= '0;
         run_mag    <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
      end else begin
         peak_valid <= mag_valid && s3_last;
         if (mag_valid) begin
            run_bin <= cand_bin;
            run_mag <= cand_mag;
         end
         if (mag_valid && s3_last) begin
            peak_bin <= cand_bin;
            peak_mag <= cand_mag;
         end
      end
   end
`else
   assign peak_valid = 1'b0;
   assign peak_bin   = '0;
   assign peak_mag   = '0;
`endif

endmodule

// File: tb/tb_fft_mag_peak.sv
// ---------------------------------------------------------------------------
// tb_fft_mag_peak
//
// Self-checking bench for fft_mag_peak. Frames are described as per-cycle
// complex inputs; the reference computes each bin's magnitude with integer
// arithmetic and scans the search window for the first maximum. Output events
// are recorded on the falling edge with the number of the rising edge that
// produced them. Peak expectations follow FFT_MAG_PEAK_EN.
// ---------------------------------------------------------------------------
module tb_fft_mag_peak;

   localparam int DW = 12;
   localparam int F  = 1024;
   localparam int BW = 11;
   localparam int LO = 2;
   localparam int HI = 1023;

   typedef struct {
      int c;
      int bin;
      int m0;
      int m1;
   } mrec_t;

   typedef struct {
      int c;
      int bin;
      int mag;
   } prec_t;

   logic          clk;
   logic          reset;
   logic          next_out;
   logic [DW-1:0] y0;
   logic [DW-1:0] y1;
   logic [DW-1:0] y2;
   logic [DW-1:0] y3;
   logic          mag_valid;
   logic [DW-1:0] mag0;
   logic [DW-1:0] mag1;
   logic [BW-1:0] mag_bin;
   logic          peak_valid;
   logic [BW-1:0] peak_bin;
   logic [DW-1:0] peak_mag;
   logic [59:0]   all_outs;

   int    n_checks = 0;
   int    n_fails  = 0;
   int    cyc      = 0;
   int    r0[F];
   int    i0[F];
   int    r1[F];
   int    i1[F];
   int    exp_mag[2*F];
   mrec_t mq[$];
   prec_t pq[$];
   string err_msg;

   fft_mag_peak #(
      .DW(DW), .FRAME_CYC(F), .BIN_W(BW), .SRCH_LO(LO), .SRCH_HI(HI)
   ) dut (
      .clk(clk), .reset(reset), .next_out(next_out),
      .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3),
      .mag_valid(mag_valid), .mag0(mag0), .mag1(mag1), .mag_bin(mag_bin),
      .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag)
   );

   assign all_outs = {mag_valid, mag0, mag1, mag_bin, peak_valid, peak_bin, peak_mag};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mag_valid) mq.push_back('{cyc, int'(mag_bin), int'(mag0), int'(mag1)});
      if (peak_valid) pq.push_back('{cyc, int'(peak_bin), int'(peak_mag)});
   end

   function automatic int ref_mag(input int re, input int im);
      int a, b, mx, mn;
      a  = (re < 0) ? -re : re;
      b  = (im < 0) ? -im : im;
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      return mx + mn / 4 + mn / 8;
   endfunction

   task automatic clear_frame();
      for (int i = 0; i < F; i++) begin
         r0[i] = 0; i0[i] = 0; r1[i] = 0; i1[i] = 0;
      end
   endtask

   task automatic random_frame();
      for (int i = 0; i < F; i++) begin
         r0[i] = int'($urandom_range(4095)) - 2048;
         i0[i] = int'($urandom_range(4095)) - 2048;
         r1[i] = int'($urandom_range(4095)) - 2048;
         i1[i] = int'($urandom_range(4095)) - 2048;
      end
   endtask

   // Bin magnitudes of the current frame and the first maximum in the window
   task automatic build_model(output int pb, output int pm);
      for (int c = 0; c < F; c++) begin
         exp_mag[2*c]   = ref_mag(r0[c], i0[c]);
         exp_mag[2*c+1] = ref_mag(r1[c], i1[c]);
      end
      pb = LO;
      pm = 0;
      for (int b = LO; b <= HI; b++) begin
         if (exp_mag[b] > pm) begin
            pm = exp_mag[b];
            pb = b;
         end
      end
   endtask

   // Caller stands 1 time unit after a rising edge; next_out is taken at edge
   // tstart and data cycle i at edge tstart+1+i.
   task automatic drive_frame(input int ncyc, output int tstart);
      next_out = 1'b1;
      tstart   = cyc + 1;
      @(posedge clk); #1;
      next_out = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         y0 = r0[i][DW-1:0];
         y1 = i0[i][DW-1:0];
         y2 = r1[i][DW-1:0];
         y3 = i1[i][DW-1:0];
         @(posedge clk); #1;
      end
      y0 = '0; y1 = '0; y2 = '0; y3 = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Locates the first recorded magnitude event that departs from the model
   // for data cycles 0..ncyc-1 of a frame whose next_out was taken at tfirst.
   function automatic int mag_stream_err(input int qoff, input int tfirst, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         int ec, eb, e0, e1;
         ec = tfirst + 3 + k;
         eb = 2 * k;
         e0 = exp_mag[2*k];
         e1 = exp_mag[2*k+1];
         if (qoff + k >= mq.size()) begin
            err_msg = $sformatf("entry %0d not recorded, required cyc=%0d bin=%0d", k, ec, eb);
            return k;
         end
         if (mq[qoff+k].c != ec || mq[qoff+k].bin != eb || mq[qoff+k].m0 != e0 || mq[qoff+k].m1 != e1) begin
            err_msg = $sformatf("entry %0d got cyc=%0d bin=%0d mag0=%0d mag1=%0d, required cyc=%0d bin=%0d mag0=%0d mag1=%0d",
                                k, mq[qoff+k].c, mq[qoff+k].bin, mq[qoff+k].m0, mq[qoff+k].m1, ec, eb, e0, e1);
            return k;
         end
      end
      return -1;
   endfunction

   task automatic test_reset();
      reset = 1'b0; next_out = 1'b0;
      y0 = '0; y1 = '0; y2 = '0; y3 = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (all_outs !== '0) begin
         n_fails++;
         $display("[TB] FAIL reset_state: outputs got %h, required 0", all_outs);
      end
      reset = 1'b1;
      mq.delete(); pq.delete();
      idle(50);
      n_checks++;
      if (mq.size() != 0 || pq.size() != 0) begin
         n_fails++;
         $display("[TB] FAIL idle_events: got %0d mag / %0d peak events, required 0 / 0", mq.size(), pq.size());
      end
      n_checks++;
      if (all_outs !== '0) begin
         n_fails++;
         $display("[TB] FAIL idle_outputs: outputs got %h, required 0", all_outs);
      end
   endtask

   task automatic test_single_tone();
      int t, pb, pm, bad;
      clear_frame();
      r1[100] = 300; i1[100] = -400;
      build_model(pb, pm);
      mq.delete(); pq.delete();
      drive_frame(F, t);
      idle(8);
      n_checks++;
      if (mq.size() != F) begin
         n_fails++;
         $display("[TB] FAIL tone_mag_count: got %0d, required %0d", mq.size(), F);
      end
      bad = mag_stream_err(0, t, F);
      n_checks++;
      if (bad != -1) begin
         n_fails++;
         $display("[TB] FAIL tone_mag_stream: %s", err_msg);
      end
      n_checks++;
      if (mq.size() <= 100 || mq[100].m1 != 512 || mq[100].bin != 200 || mq[100].c != t + 103) begin
         n_fails++;
         $display("[TB] FAIL tone_spot: got %0d events (entry 100 mag1/bin checked), required mag1=512 bin=200 cyc=%0d", mq.size(), t + 103);
      end
`ifdef FFT_MAG_PEAK_EN
      n_checks++;
      if (pq.size() != 1) begin
         n_fails++;
         $display("[TB] FAIL tone_peak_count: got %0d, required 1", pq.size());
      end else begin
         n_checks++;
         if (pq[0].c != t + F + 3 || pq[0].bin != pb || pq[0].mag != pm || pq[0].bin != 201) begin
            n_fails++;
            $display("[TB] FAIL tone_peak: got cyc=%0d bin=%0d mag=%0d, required cyc=%0d bin=%0d mag=%0d",
                     pq[0].c, pq[0].bin, pq[0].mag, t + F + 3, pb, pm);
         end
      end
      n_checks++;
      if (peak_bin !== BW'(pb) || peak_mag !== DW'(pm) || peak_valid !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL tone_peak_hold: got bin=%0d mag=%0d valid=%b, required bin=%0d mag=%0d valid=0", peak_bin, peak_mag, peak_valid, pb, pm);
      end
`else
      n_checks++;
      if (pq.size() != 0 || peak_bin !== '0 || peak_mag !== '0) begin
         n_fails++;
         $display("[TB] FAIL tone_peak_off: got %0d pulses bin=%0d mag=%0d, required 0 0 0", pq.size(), peak_bin, peak_mag);
      end
`endif
   endtask

   task automatic test_saturation();
      int t, pb, pm, bad;
      for (int i = 0; i < F; i++) begin
         r0[i] = -2048; i0[i] = -2048; r1[i] = -2048; i1[i] = -2048;
      end
      build_model(pb, pm);
      mq.delete(); pq.delete();
      drive_frame(F, t);
      idle(8);
      bad = mag_stream_err(0, t, F);
      n_checks++;
      if (bad != -1 || mq.size() != F) begin
         n_fails++;
         $display("[TB] FAIL sat_mag_stream: %0d events, %s", mq.size(), err_msg);
      end
      n_checks++;
      if (mq.size() < F || mq[0].m0 != 2816 || mq[F-1].m1 != 2816) begin
         n_fails++;
         $display("[TB] FAIL sat_value: got %0d events, required first mag0 and last mag1 = 2816", mq.size());
      end
`ifdef FFT_MAG_PEAK_EN
      n_checks++;
      if (pq.size() != 1 || pq[0].bin != 2 || pq[0].mag != 2816 || pq[0].c != t + F + 3) begin
         n_fails++;
         $display("[TB] FAIL sat_peak: got %0d pulses, bin=%0d mag=%0d, required 1 pulse bin=2 mag=2816 cyc=%0d",
                  pq.size(), peak_bin, peak_mag, t + F + 3);
      end
`else
      n_checks++;
      if (pq.size() != 0 || peak_bin !== '0 || peak_mag !== '0) begin
         n_fails++;
         $display("[TB] FAIL sat_peak_off: got %0d pulses bin=%0d mag=%0d, required 0 0 0", pq.size(), peak_bin, peak_mag);
      end
`endif
   endtask

   task automatic test_window();
      int t, pb, pm, bad;
      clear_frame();
      r0[0] = 2000; r0[750] = 2000; r0[300] = 10;
      build_model(pb, pm);
      mq.delete(); pq.delete();
      drive_frame(F, t);
      idle(8);
      bad = mag_stream_err(0, t, F);
      n_checks++;
      if (bad != -1 || mq.size() != F) begin
         n_fails++;
         $display("[TB] FAIL window_mag_stream: %0d events, %s", mq.size(), err_msg);
      end
`ifdef FFT_MAG_PEAK_EN
      n_checks++;
      if (pq.size() != 1 || pq[0].bin != 600 || pq[0].mag != 10 || pq[0].bin != pb) begin
         n_fails++;
         $display("[TB] FAIL window_peak: got %0d pulses bin=%0d mag=%0d, required 1 pulse bin=600 mag=10", pq.size(), peak_bin, peak_mag);
      end
`else
      n_checks++;
      if (pq.size() != 0 || peak_bin !== '0 || peak_mag !== '0) begin
         n_fails++;
         $display("[TB] FAIL window_peak_off: got %0d pulses bin=%0d mag=%0d, required 0 0 0", pq.size(), peak_bin, peak_mag);
      end
`endif
   endtask

   task automatic test_restart();
      int t1, t2, pb, pm, bad;
      clear_frame();
      r1[100] = 300; i1[100] = -400;
      build_model(pb, pm);
      mq.delete(); pq.delete();
      drive_frame(499, t1);
      drive_frame(F, t2);
      idle(8);
      n_checks++;
      if (mq.size() != 499 + F) begin
         n_fails++;
         $display("[TB] FAIL restart_mag_count: got %0d, required %0d", mq.size(), 499 + F);
      end
      bad = mag_stream_err(0, t1, 499);
      if (bad == -1) bad = mag_stream_err(499, t2, F);
      n_checks++;
      if (bad != -1) begin
         n_fails++;
         $display("[TB] FAIL restart_mag_stream: %s", err_msg);
      end
`ifdef FFT_MAG_PEAK_EN
      n_checks++;
      if (pq.size() != 1 || pq[0].c != t1 + 500 + F + 3 || pq[0].bin != 201 || pq[0].mag != pm) begin
         n_fails++;
         $display("[TB] FAIL restart_peak: got %0d pulses bin=%0d mag=%0d, required 1 pulse at cyc=%0d bin=201 mag=%0d",
                  pq.size(), peak_bin, peak_mag, t1 + 500 + F + 3, pm);
      end
`else
      n_checks++;
      if (pq.size() != 0 || peak_bin !== '0 || peak_mag !== '0) begin
         n_fails++;
         $display("[TB] FAIL restart_peak_off: got %0d pulses bin=%0d mag=%0d, required 0 0 0", pq.size(), peak_bin, peak_mag);
      end
`endif
   endtask

   task automatic test_random();
      int t, pb, pm, bad;
      for (int n = 0; n < 2; n++) begin
         random_frame();
         build_model(pb, pm);
         mq.delete(); pq.delete();
         drive_frame(F, t);
         idle(8);
         bad = mag_stream_err(0, t, F);
         n_checks++;
         if (bad != -1 || mq.size() != F) begin
            n_fails++;
            $display("[TB] FAIL random%0d_mag_stream: %0d events, %s", n, mq.size(), err_msg);
         end
`ifdef FFT_MAG_PEAK_EN
         n_checks++;
         if (pq.size() != 1 || pq[0].bin != pb || pq[0].mag != pm || pq[0].c != t + F + 3) begin
            n_fails++;
            $display("[TB] FAIL random%0d_peak: got %0d pulses bin=%0d mag=%0d, required 1 pulse bin=%0d mag=%0d",
                     n, pq.size(), peak_bin, peak_mag, pb, pm);
         end
`else
         n_checks++;
         if (pq.size() != 0 || peak_bin !== '0 || peak_mag !== '0) begin
            n_fails++;
            $display("[TB] FAIL random%0d_peak_off: got %0d pulses bin=%0d mag=%0d, required 0 0 0", n, pq.size(), peak_bin, peak_mag);
         end
`endif
      end
   endtask

   task automatic test_reset_midframe();
      int t;
      random_frame();
      drive_frame(300, t);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (all_outs !== '0) begin
         n_fails++;
         $display("[TB] FAIL midreset_outputs: got %h, required 0", all_outs);
      end
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      mq.delete(); pq.delete();
      idle(F + 20);
      n_checks++;
      if (mq.size() != 0 || pq.size() != 0 || all_outs !== '0) begin
         n_fails++;
         $display("[TB] FAIL midreset_quiet: got %0d mag / %0d peak events outs=%h, required 0 / 0 / 0", mq.size(), pq.size(), all_outs);
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2, pb, pm, bad;
      random_frame();
      build_model(pb, pm);
      mq.delete(); pq.delete();
      drive_frame(F, t1);
      drive_frame(F, t2);
      idle(8);
      n_checks++;
      if (mq.size() != 2 * F) begin
         n_fails++;
         $display("[TB] FAIL b2b_mag_count: got %0d, required %0d", mq.size(), 2 * F);
      end
      bad = mag_stream_err(0, t1, F);
      if (bad == -1) bad = mag_stream_err(F, t1 + F + 1, F);
      n_checks++;
      if (bad != -1) begin
         n_fails++;
         $display("[TB] FAIL b2b_mag_stream: %s", err_msg);
      end
`ifdef FFT_MAG_PEAK_EN
      n_checks++;
      if (pq.size() == 0 || pq[pq.size()-1].c != t1 + 2 * F + 4 || pq[pq.size()-1].bin != pb || pq[pq.size()-1].mag != pm) begin
         n_fails++;
         $display("[TB] FAIL b2b_peak: got %0d pulses, last bin=%0d mag=%0d, required final pulse cyc=%0d bin=%0d mag=%0d",
                  pq.size(), peak_bin, peak_mag, t1 + 2 * F + 4, pb, pm);
      end
`else
      n_checks++;
      if (pq.size() != 0 || peak_bin !== '0 || peak_mag !== '0) begin
         n_fails++;
         $display("[TB] FAIL b2b_peak_off: got %0d pulses bin=%0d mag=%0d, required 0 0 0", pq.size(), peak_bin, peak_mag);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_tone();
      test_saturation();
      test_window();
      test_restart();
      test_random();
      test_reset_midframe();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
